// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one synchronous single-port 256x8 RAM between the
//            instruction fetch (if_*), data load/store (dm_*) and
//            loader/debug (ld_*) requesters, one access per cycle.
//            Fixed priority ld > dm > if. Each grant is a one-cycle pulse
//            and read data returns two cycles after the request is sampled.
// Options  : define STARVE_GUARD_EN to promote fetch above dm after
//            MAX_WAIT consecutive denials (MAX_WAIT must be 1..7).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // instruction fetch
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    // data load/store
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    // program loader / debug
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    // RAM command / response
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;
    localparam logic [1:0] OWN_LD   = 2'd3;

    localparam logic [2:0] WAIT_LIMIT = 3'(MAX_WAIT);

    // The 3-bit wait counter cannot represent limits outside 1..7.
    if (MAX_WAIT < 1 || MAX_WAIT > 7) begin : g_max_wait_check
        $error("mem_port_arbiter: MAX_WAIT must be in 1..7");
    end

    // Command stage (cycle N+1): current owner and whether it is a read
    logic [1:0]    owner_q, owner_d;
    logic          rd_q, rd_d;
    // Response stage (cycle N+2): owner/read flag delayed one cycle
    logic [1:0]    rsp_owner_q;
    logic          rsp_rd_q;
    // RAM command registers
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic          if_elig, dm_elig, ld_elig;
    logic          if_promote;

    // A requester whose grant is showing this cycle sits out one arbitration,
    // which covers the cycle it needs to drop its level request.
    assign if_elig = if_req & (owner_q != OWN_IF);
    assign dm_elig = dm_req & (owner_q != OWN_DM);
    assign ld_elig = ld_req & (owner_q != OWN_LD);

`ifdef STARVE_GUARD_EN
    logic [2:0] wait_q, wait_d;

    assign if_promote = (wait_q >= WAIT_LIMIT);

    // Count consecutive denials of an eligible fetch; saturate at 7
    always_comb begin
        wait_d = wait_q;
        if (!if_req || owner_d == OWN_IF) begin
            wait_d = '0;
        end else if (if_elig && wait_q != 3'd7) begin
            wait_d = wait_q + 3'd1;
        end
    end

    // Fetch wait counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign if_promote = 1'b0;
`endif

    // Pick the winner: ld always first, promoted fetch next, then dm, then fetch
    always_comb begin
        owner_d = OWN_NONE;
        if (ld_elig) begin
            owner_d = OWN_LD;
        end else if (if_elig && if_promote) begin
            owner_d = OWN_IF;
        end else if (dm_elig) begin
            owner_d = OWN_DM;
        end else if (if_elig) begin
            owner_d = OWN_IF;
        end
    end

    // Load the RAM command from the winner; address/data hold when idle
    always_comb begin
        rd_d        = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (owner_d)
            OWN_LD: begin
                rd_d        = ~ld_we;
                mem_en_d    = 1'b1;
                mem_we_d    = ld_we;
                mem_addr_d  = ld_addr;
                mem_wdata_d = ld_wdata;
            end
            OWN_DM: begin
                rd_d        = ~dm_we;
                mem_en_d    = 1'b1;
                mem_we_d    = dm_we;
                mem_addr_d  = dm_addr;
                mem_wdata_d = dm_wdata;
            end
            OWN_IF: begin
                rd_d        = 1'b1;
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b0;
                mem_addr_d  = if_addr;
            end
            default: begin
            end
        endcase
    end

    // Command and response pipeline registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q     <= OWN_NONE;
            rd_q        <= 1'b0;
            rsp_owner_q <= OWN_NONE;
            rsp_rd_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            owner_q     <= owner_d;
            rd_q        <= rd_d;
            rsp_owner_q <= owner_q;
            rsp_rd_q    <= rd_q;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Strobes are qualified by rst_n so that asserting reset cancels a pending
    // grant, RAM command or read response in the same cycle.
    assign ld_gnt    = rst_n & (owner_q == OWN_LD);
    assign dm_gnt    = rst_n & (owner_q == OWN_DM);
    assign if_gnt    = rst_n & (owner_q == OWN_IF);
    assign ld_rvalid = rst_n & rsp_rd_q & (rsp_owner_q == OWN_LD);
    assign dm_rvalid = rst_n & rsp_rd_q & (rsp_owner_q == OWN_DM);
    assign if_rvalid = rst_n & rsp_rd_q & (rsp_owner_q == OWN_IF);

    // Read data is broadcast; only the owner's rvalid qualifies it
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign ld_rdata  = mem_rdata;

    assign mem_en    = rst_n & mem_en_q;
    assign mem_we    = rst_n & mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter with a behavioural
//            synchronous 256x8 RAM. Table of single-requester accesses plus
//            hand-written multi-cycle sequences.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       if_req = 1'b0, dm_req = 1'b0, ld_req = 1'b0;
    logic       dm_we = 1'b0, ld_we = 1'b0;
    logic [7:0] if_addr = '0, dm_addr = '0, ld_addr = '0;
    logic [7:0] dm_wdata = '0, ld_wdata = '0;
    logic       if_gnt, dm_gnt, ld_gnt;
    logic       if_rvalid, dm_rvalid, ld_rvalid;
    logic [7:0] if_rdata, dm_rdata, ld_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = '0;

    int n_pass  = 0;
    int n_total = 0;

    mem_port_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous single-port RAM
    logic [7:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        logic [1:0] port;      // 0 = if, 1 = dm, 2 = ld
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic clear_reqs();
        if_req = 1'b0; dm_req = 1'b0; ld_req = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        case (v.port)
            2'd0: begin if_req = 1'b1; if_addr = v.addr; end
            2'd1: begin dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; end
            default: begin ld_req = 1'b1; ld_we = v.we; ld_addr = v.addr; ld_wdata = v.wdata; end
        endcase
    endtask

    function automatic logic [7:0] port_rdata(input logic [1:0] p);
        case (p)
            2'd0:    return if_rdata;
            2'd1:    return dm_rdata;
            default: return ld_rdata;
        endcase
    endfunction

    function automatic logic [31:0] all_outputs();
        return {4'b0, if_gnt, dm_gnt, ld_gnt, if_rvalid, dm_rvalid, ld_rvalid,
                mem_en, mem_we, mem_addr, mem_wdata};
    endfunction

    logic [2:0] sim_gnt [5];
    logic [2:0] sim_rv  [5];
    logic [2:0] sf_gnt  [4];
    logic [2:0] sf_rv   [4];
    int         first_if;
    int         exp_first_if;

    initial begin
        //                 port  we    addr   wdata  exp_rdata
        vecs[0] = '{2'd2, 1'b1, 8'h00, 8'h12, 8'h00};
        vecs[1] = '{2'd2, 1'b1, 8'hFF, 8'hDC, 8'h00};
        vecs[2] = '{2'd2, 1'b1, 8'h03, 8'h77, 8'h00};
        vecs[3] = '{2'd0, 1'b0, 8'h00, 8'h00, 8'h12};
        vecs[4] = '{2'd1, 1'b0, 8'hFF, 8'h00, 8'hDC};
        vecs[5] = '{2'd2, 1'b0, 8'h03, 8'h00, 8'h77};
        vecs[6] = '{2'd1, 1'b1, 8'h20, 8'h5A, 8'h00};
        vecs[7] = '{2'd0, 1'b0, 8'h20, 8'h00, 8'h5A};
        vecs[8] = '{2'd2, 1'b0, 8'h00, 8'h00, 8'h12};

        // {ld,dm,if} expectations for the three-way contention sequence
        sim_gnt = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b000};
        sim_rv  = '{3'b000, 3'b000, 3'b010, 3'b001, 3'b000};
        // store then fetch of the same address, back to back
        sf_gnt  = '{3'b010, 3'b001, 3'b000, 3'b000};
        sf_rv   = '{3'b000, 3'b000, 3'b001, 3'b000};

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table of single accesses ----------------
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_gnt", i), 32'({ld_gnt, dm_gnt, if_gnt}), 32'(3'b001 << vecs[i].port));
            check($sformatf("v%0d_cmd", i), 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, vecs[i].we, vecs[i].addr}));
            if (vecs[i].we)
                check($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vecs[i].wdata));
            clear_reqs();
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rvalid", i), 32'({ld_rvalid, dm_rvalid, if_rvalid}),
                  vecs[i].we ? 32'h0 : 32'(3'b001 << vecs[i].port));
            if (!vecs[i].we)
                check($sformatf("v%0d_rdata", i), 32'(port_rdata(vecs[i].port)), 32'(vecs[i].exp_rdata));
        end

        // ---------------- all three request together ----------------
        @(negedge clk);
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h10; ld_wdata = 8'hAA;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'hFF;
        if_req = 1'b1; if_addr = 8'h00;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("sim%0d_gnt", c), 32'({ld_gnt, dm_gnt, if_gnt}), 32'(sim_gnt[c]));
            check($sformatf("sim%0d_rvalid", c), 32'({ld_rvalid, dm_rvalid, if_rvalid}), 32'(sim_rv[c]));
            if (c == 2) check("sim_dm_rdata", 32'(dm_rdata), 32'hDC);
            if (c == 3) check("sim_if_rdata", 32'(if_rdata), 32'h12);
            if (ld_gnt) ld_req = 1'b0;
            if (dm_gnt) dm_req = 1'b0;
            if (if_gnt) if_req = 1'b0;
        end
        clear_reqs();

        // ---------------- store then fetch of same address ----------------
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h03; dm_wdata = 8'h3B;
        if_req = 1'b1; if_addr = 8'h03;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("sf%0d_gnt", c), 32'({ld_gnt, dm_gnt, if_gnt}), 32'(sf_gnt[c]));
            check($sformatf("sf%0d_rvalid", c), 32'({ld_rvalid, dm_rvalid, if_rvalid}), 32'(sf_rv[c]));
            if (c == 2) check("sf_if_rdata", 32'(if_rdata), 32'h3B);
            if (dm_gnt) dm_req = 1'b0;
            if (if_gnt) if_req = 1'b0;
        end
        clear_reqs();

        // ---------------- reset while a load is outstanding ----------------
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'hFF;
        @(posedge clk);
        #1;
        check("rst_dm_gnt", 32'(dm_gnt), 32'h1);
        dm_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_no_rvalid", 32'(dm_rvalid), 32'h0);
        @(posedge clk);
        #1;
        check("rst_outputs", all_outputs(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_no_late_rvalid", 32'({ld_rvalid, dm_rvalid, if_rvalid}), 32'h0);

        // ---------------- fetch against continuous ld + dm traffic ----------------
`ifdef STARVE_GUARD_EN
        exp_first_if = 5;
`else
        exp_first_if = -1;
`endif
        first_if = -1;
        @(negedge clk);
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h00;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'hFF;
        if_req = 1'b1; if_addr = 8'h03;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("starve%0d_onehot", k),
                  32'({ld_gnt, dm_gnt, if_gnt} & ({ld_gnt, dm_gnt, if_gnt} - 3'd1)), 32'h0);
            if (if_gnt && first_if < 0) begin
                first_if = k;
                if_req   = 1'b0;
            end
        end
        check("starve_first_if_gnt", 32'(first_if), 32'(exp_first_if));
        clear_reqs();

        // ---------------- idle ----------------
        repeat (3) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("idle%0d", k),
                  32'({mem_en, ld_gnt, dm_gnt, if_gnt, ld_rvalid, dm_rvalid, if_rvalid}), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 256x8 unified memory between three requesters, one access per cycle.
- Requesters: instruction fetch (if_*), data load/store (dm_*), external program loader/debug (ld_*).
- Sits between the processor core and the synchronous single-port RAM. Replaces direct combinational memory indexing.
- Owns the request/grant handshake, the RAM command registers and read-data return routing.

Parameters:
- AW, 8, address width (256-entry memory).
- DW, 8, data width.
- MAX_WAIT, 4, consecutive fetch denials tolerated before fetch is promoted (used only with STARVE_GUARD_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, active-low, synchronous.
- if_req  in  1  fetch request, level, held until if_gnt.
- if_addr  in  AW  fetch address (PC).
- if_gnt  out  1  fetch granted, one-cycle pulse.
- if_rvalid  out  1  if_rdata valid, one-cycle pulse.
- if_rdata  out  DW  fetched instruction byte.
- dm_req  in  1  data request, level.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  AW  data address (Rrs for load, Rrd for store).
- dm_wdata  in  DW  store data.
- dm_gnt  out  1  data granted pulse.
- dm_rvalid  out  1  load data valid pulse.
- dm_rdata  out  DW  load data.
- ld_req  in  1  loader request, level.
- ld_we  in  1  loader write enable.
- ld_addr  in  AW  loader address.
- ld_wdata  in  DW  loader write data.
- ld_gnt  out  1  loader granted pulse.
- ld_rvalid  out  1  loader read data valid pulse.
- ld_rdata  out  DW  loader read data.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset values:
  - all *_gnt and *_rvalid = 0.
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - owner register = NONE.
  - fetch wait counter = 0.
- Arbitration runs at every rising edge with rst_n=1.
  - Eligible = req high AND that requester's gnt not currently high. A requester can therefore be granted at most every other cycle, which absorbs its req drop latency.
  - Fixed priority: ld > dm > if.
  - Winner: its gnt goes 1 for exactly one cycle. mem_en=1 and mem_we/mem_addr/mem_wdata are loaded from the winner's inputs. owner is recorded, with a read flag = !we.
  - No eligible requester: mem_en=0, mem_we=0. mem_addr/mem_wdata hold their values.
- Timing (request sampled at edge N):
  - gnt and RAM command valid in cycle N+1.
  - RAM performs the access at edge N+2.
  - For reads, <owner>_rvalid=1 in cycle N+2, with <owner>_rdata=mem_rdata.
  - Writes never assert rvalid.
- rdata routing: all three *_rdata ports are driven by mem_rdata. Only the owner's rvalid qualifies it.
- Back-to-back grants are allowed: a new command can issue in cycle N+2 while a read response is returned. Response tracking is a one-deep pipeline register (owner and read flag delayed one cycle).
- Ordering: accesses reach the RAM strictly in grant order. A store granted at N followed by a fetch of the same address granted at N+1 returns the new data.
- Reset mid-operation: an outstanding read is dropped, no rvalid after reset. A pending grant is cleared and the RAM command is deasserted in the same cycle.
- req dropped before grant: no grant, no side effect.
- Address wrap: none internal; addresses pass through unmodified.

Optional Feature:
- Macro: STARVE_GUARD_EN.
- Defined:
  - The 3-bit wait counter increments each edge where if_req is eligible but not granted.
  - It clears on if_gnt or when if_req=0.
  - When the counter reaches MAX_WAIT, fetch is promoted above dm (still below ld) for the next arbitration. The counter clears on the resulting grant.
- Undefined: the counter logic is absent and pure fixed priority applies. dm may starve fetch indefinitely.

Test Plan:
- Reset, then single fetch: if_req=1, if_addr=0x00, RAM[0]=0x12 -> if_gnt high 1 cycle later; if_rvalid high 2 cycles after sampling with if_rdata=0x12; no dm/ld pulses.
- Simultaneous requests: if_req, dm_req (load 0xFF, RAM=0xDC) and ld_req (write 0x10=0xAA) all high -> grants in order ld, dm, if on consecutive cycles; dm_rdata=0xDC with dm_rvalid; ld_rvalid never asserts.
- Store then fetch same address: dm store 0x3B to 0x03, then if_addr=0x03 -> if_rdata=0x3B.
- Reset mid-read: rst_n=0 in the cycle after dm_gnt for a load -> no dm_rvalid; all outputs at reset values on the next edge.
- STARVE_GUARD_EN, MAX_WAIT=4: dm_req held high continuously with if_req high -> if_gnt within 5 grants of fetch becoming eligible. Without the macro -> no if_gnt while dm_req stays high.
- Idle: all req=0 for 10 cycles -> mem_en=0 and every gnt/rvalid=0 throughout.
